// File: rtl/mem_responder.sv
// Memory-side responder: routes CPU accesses to block RAM or a small MMIO bank (SW, LED, TMR, STAT).
// Latency: ready pulses 2 cycles after req is sampled, 3 for RAM reads; next access is sampled no sooner than the cycle after DONE.
// Backpressure: req is held until ready; inputs are latched in IDLE and ignored until the next IDLE.
module mem_responder #(
    parameter int               WIDTH     = 16,
    parameter int               RAM_AW    = 12,
    parameter int               SWL       = 10,
    parameter logic [WIDTH-1:0] MMIO_BASE = 16'hFFF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_din,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [WIDTH-1:0]  ram_dout,
    input  logic [SWL-1:0]    switches,
    output logic [SWL-1:0]    leds,
    output logic              bad_addr
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [WIDTH-1:0] SW_A   = MMIO_BASE;
    localparam logic [WIDTH-1:0] LED_A  = MMIO_BASE + WIDTH'(1);
    localparam logic [WIDTH-1:0] TMR_A  = MMIO_BASE + WIDTH'(2);
    localparam logic [WIDTH-1:0] STAT_A = MMIO_BASE + WIDTH'(3);

    state_t           state;
    logic [WIDTH-1:0] lat_addr;
    logic             lat_we;
    logic [SWL-1:0]   sw_s1, sw_s2;
    logic [WIDTH-1:0] timer;
    logic [WIDTH-1:0] mmio_rd;

    logic req_ram, lat_ram, hit_sw, hit_led, hit_tmr, hit_stat, unmapped;
    logic in_access, tmr_clr, stat_clr, bad_set;

    assign req_ram   = (addr >> RAM_AW) == '0;
    assign lat_ram   = (lat_addr >> RAM_AW) == '0;
    assign hit_sw    = lat_addr == SW_A;
    assign hit_led   = lat_addr == LED_A;
    assign hit_tmr   = lat_addr == TMR_A;
    assign hit_stat  = lat_addr == STAT_A;
    assign unmapped  = !lat_ram && !(hit_sw || hit_led || hit_tmr || hit_stat);
    assign in_access = state == ACCESS;
    assign tmr_clr   = in_access && lat_we && hit_tmr;
    assign stat_clr  = in_access && lat_we && hit_stat;
    assign bad_set   = in_access && unmapped;

    always_comb begin
        mmio_rd = '0;
        if (hit_sw)
            mmio_rd = {{(WIDTH-SWL){1'b0}}, sw_s2};
        else if (hit_led)
            mmio_rd = {{(WIDTH-SWL){1'b0}}, leds};
        else if (hit_tmr)
            mmio_rd = timer;
        else if (hit_stat)
            mmio_rd = {{(WIDTH-1){1'b0}}, bad_addr};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_we   <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b0;
            leds     <= '0;
            timer    <= '0;
            bad_addr <= 1'b0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;
            timer <= tmr_clr ? '0 : timer + WIDTH'(1);
            // An unmapped access and a STAT clear cannot share one access, but set wins regardless.
            if (bad_set)
                bad_addr <= 1'b1;
            else if (stat_clr)
                bad_addr <= 1'b0;

            ready  <= 1'b0;
            ram_en <= 1'b0;
            ram_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr <= addr;
                        lat_we   <= we;
                        ram_addr <= addr[RAM_AW-1:0];
                        ram_din  <= wdata;
                        ram_en   <= req_ram;
                        ram_we   <= we && req_ram;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_ram && !lat_we) begin
                        state <= WAIT;
                    end else begin
                        if (!lat_ram) begin
                            if (lat_we) begin
                                // ram_din doubles as the latched write data for MMIO
                                if (hit_led)
                                    leds <= ram_din[SWL-1:0];
                            end else begin
                                rdata <= mmio_rd;
                            end
                        end
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
                WAIT: begin
                    rdata <= ram_dout;
                    ready <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM, MMIO, timer, unmapped decode, handshake and reset-abort.
`timescale 1ns/1ps
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [15:0] addr, wdata, rdata;
    logic        ready;
    logic [11:0] ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        ram_we, ram_en;
    logic [9:0]  switches, leds;
    logic        bad_addr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(16), .RAM_AW(12), .SWL(10), .MMIO_BASE(16'hFFF0)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_en(ram_en), .ram_dout(ram_dout),
        .switches(switches), .leds(leds), .bad_addr(bad_addr)
    );

    // Synchronous single-port block RAM model, preloaded with zeros
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Starts in IDLE at #1 after an edge; lat counts edges from the sampling edge (1) to ready.
    // Ends one edge after ready, back in IDLE.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat, output int wec);
        we = w; addr = a; wdata = d; req = 1'b1;
        lat = 0; wec = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ram_we) wec++;
            if (ready) begin
                lat = i;
                break;
            end
        end
        req = 1'b0;
        rd  = rdata;
        @(posedge clk); #1;
    endtask

    logic [15:0] rd;
    int lat, wec, first, second, pulses;

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0; switches = 10'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 16'h0000);
        check("rst_ctl", {12'h0, ready, ram_en, ram_we, bad_addr}, 16'h0000);
        check("rst_leds", {6'h0, leds}, 16'h0000);
        check("rst_ram_bus", {4'h0, ram_addr} | ram_din, 16'h0000);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset asserted while in ACCESS of a RAM write
        we = 1'b1; addr = 16'h0010; wdata = 16'hBEEF; req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; #1; req = 1'b0;
        check("midrst_ctl", {13'h0, ready, ram_en, ram_we}, 16'h0000);
        check("midrst_bus", {4'h0, ram_addr} | ram_din, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("midrst_no_ready", 16'(pulses), 16'd0);
        access(1'b0, 16'h0010, 16'h0, rd, lat, wec);
        check("midrst_readback", rd, 16'h0000);

        // RAM write then read
        access(1'b1, 16'h0ABC, 16'h1234, rd, lat, wec);
        check("ram_wr_lat", 16'(lat), 16'd2);
        check("ram_wr_we_cycles", 16'(wec), 16'd1);
        access(1'b0, 16'h0ABC, 16'h0, rd, lat, wec);
        check("ram_rd_lat", 16'(lat), 16'd3);
        check("ram_rd_data", rd, 16'h1234);
        repeat (3) @(posedge clk);
        #1;
        check("ram_rd_hold", rdata, 16'h1234);

        // Switches and LEDs
        switches = 10'h2A5;
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 16'hFFF0, 16'h0, rd, lat, wec);
        check("sw_read", rd, 16'h02A5);
        check("sw_lat", 16'(lat), 16'd2);
        access(1'b1, 16'hFFF1, 16'hFFFF, rd, lat, wec);
        check("led_out", {6'h0, leds}, 16'h03FF);
        check("led_wr_keeps_rdata", rd, 16'h02A5);
        access(1'b0, 16'hFFF1, 16'h0, rd, lat, wec);
        check("led_read", rd, 16'h03FF);

        // Unmapped and STAT
        access(1'b0, 16'h8000, 16'h0, rd, lat, wec);
        check("unmap_rdata", rd, 16'h0000);
        check("unmap_lat", 16'(lat), 16'd2);
        check("unmap_bad", {15'h0, bad_addr}, 16'h0001);
        access(1'b1, 16'hFFF7, 16'hDEAD, rd, lat, wec);
        check("unmap_wr_leds", {6'h0, leds}, 16'h03FF);
        check("unmap_wr_no_ram", 16'(wec), 16'd0);
        access(1'b0, 16'hFFF3, 16'h0, rd, lat, wec);
        check("stat_read_set", rd, 16'h0001);
        access(1'b1, 16'hFFF3, 16'h0, rd, lat, wec);
        check("stat_clear", {15'h0, bad_addr}, 16'h0000);
        access(1'b0, 16'hFFF3, 16'h0, rd, lat, wec);
        check("stat_read_clr", rd, 16'h0000);

        // Timer: cleared on write commit edge E, holds k after edge E+k.
        // Read samples at E+2+n and returns the value during its ACCESS cycle: 2+n.
        access(1'b1, 16'hFFF2, 16'h0, rd, lat, wec);
        repeat (8) @(posedge clk);
        #1;
        access(1'b0, 16'hFFF2, 16'h0, rd, lat, wec);
        check("tmr_10", rd, 16'd10);
        access(1'b1, 16'hFFF2, 16'h0, rd, lat, wec);
        repeat (65534) @(posedge clk);
        #1;
        access(1'b0, 16'hFFF2, 16'h0, rd, lat, wec);
        check("tmr_wrap", rd, 16'h0000);

        // req held high across two RAM reads
        we = 1'b0; addr = 16'h0ABC; req = 1'b1;
        first = 0; second = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                if (first == 0) first = i;
                else begin
                    second = i;
                    req = 1'b0;
                    break;
                end
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("b2b_first", 16'(first), 16'd3);
        check("b2b_second", 16'(second), 16'd7);
        check("b2b_rdata", rdata, 16'h1234);

        // req dropped after sampling; later input changes must be ignored
        we = 1'b1; addr = 16'h0020; wdata = 16'h5A5A; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; addr = 16'h0ABC; wdata = 16'h0000;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("drop_req_pulses", 16'(pulses), 16'd1);
        access(1'b0, 16'h0020, 16'h0, rd, lat, wec);
        check("drop_req_commit", rd, 16'h5A5A);
        access(1'b0, 16'h0ABC, 16'h0, rd, lat, wec);
        check("drop_req_other", rd, 16'h1234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
